// File: rtl/aes_sub_shift_seq_pkg.sv
// Shared constants, FSM encoding and ShiftRows index mapping for the
// AES SubBytes+ShiftRows engines.
package aes_sub_shift_seq_pkg;

  localparam int AES_NB_BYTES = 16;
  localparam int AES_STATE_W  = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Byte index i sits at row i%4, column i/4; source (r,c) lands at (r,(c-r) mod 4).
  function automatic logic [3:0] sr_dest(input logic [3:0] src);
    logic [1:0] row;
    logic [1:0] col;
    row = src[1:0];
    col = src[3:2];
    return {2'(col - row), row};
  endfunction

endpackage

// File: rtl/aes_sub_shift_seq_if.sv
// Input/output handshake bundle of the SubBytes+ShiftRows engine.
interface aes_sub_shift_seq_if;
  import aes_sub_shift_seq_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_STATE_W-1:0] in_state;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_STATE_W-1:0] out_state;
  logic                   busy;

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/aes_sub_shift_seq_sbox.sv
// Forward AES S-box (FIPS-197), purely combinational lookup.
module aes_sub_shift_seq_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_c
);

  // Full 256-entry substitution table.
  always_comb begin
    o_c = 8'h00;
    case (i_a)
      8'h00: o_c = 8'h63; 8'h01: o_c = 8'h7c; 8'h02: o_c = 8'h77; 8'h03: o_c = 8'h7b; 8'h04: o_c = 8'hf2; 8'h05: o_c = 8'h6b; 8'h06: o_c = 8'h6f; 8'h07: o_c = 8'hc5;
      8'h08: o_c = 8'h30; 8'h09: o_c = 8'h01; 8'h0a: o_c = 8'h67; 8'h0b: o_c = 8'h2b; 8'h0c: o_c = 8'hfe; 8'h0d: o_c = 8'hd7; 8'h0e: o_c = 8'hab; 8'h0f: o_c = 8'h76;
      8'h10: o_c = 8'hca; 8'h11: o_c = 8'h82; 8'h12: o_c = 8'hc9; 8'h13: o_c = 8'h7d; 8'h14: o_c = 8'hfa; 8'h15: o_c = 8'h59; 8'h16: o_c = 8'h47; 8'h17: o_c = 8'hf0;
      8'h18: o_c = 8'had; 8'h19: o_c = 8'hd4; 8'h1a: o_c = 8'ha2; 8'h1b: o_c = 8'haf; 8'h1c: o_c = 8'h9c; 8'h1d: o_c = 8'ha4; 8'h1e: o_c = 8'h72; 8'h1f: o_c = 8'hc0;
      8'h20: o_c = 8'hb7; 8'h21: o_c = 8'hfd; 8'h22: o_c = 8'h93; 8'h23: o_c = 8'h26; 8'h24: o_c = 8'h36; 8'h25: o_c = 8'h3f; 8'h26: o_c = 8'hf7; 8'h27: o_c = 8'hcc;
      8'h28: o_c = 8'h34; 8'h29: o_c = 8'ha5; 8'h2a: o_c = 8'he5; 8'h2b: o_c = 8'hf1; 8'h2c: o_c = 8'h71; 8'h2d: o_c = 8'hd8; 8'h2e: o_c = 8'h31; 8'h2f: o_c = 8'h15;
      8'h30: o_c = 8'h04; 8'h31: o_c = 8'hc7; 8'h32: o_c = 8'h23; 8'h33: o_c = 8'hc3; 8'h34: o_c = 8'h18; 8'h35: o_c = 8'h96; 8'h36: o_c = 8'h05; 8'h37: o_c = 8'h9a;
      8'h38: o_c = 8'h07; 8'h39: o_c = 8'h12; 8'h3a: o_c = 8'h80; 8'h3b: o_c = 8'he2; 8'h3c: o_c = 8'heb; 8'h3d: o_c = 8'h27; 8'h3e: o_c = 8'hb2; 8'h3f: o_c = 8'h75;
      8'h40: o_c = 8'h09; 8'h41: o_c = 8'h83; 8'h42: o_c = 8'h2c; 8'h43: o_c = 8'h1a; 8'h44: o_c = 8'h1b; 8'h45: o_c = 8'h6e; 8'h46: o_c = 8'h5a; 8'h47: o_c = 8'ha0;
      8'h48: o_c = 8'h52; 8'h49: o_c = 8'h3b; 8'h4a: o_c = 8'hd6; 8'h4b: o_c = 8'hb3; 8'h4c: o_c = 8'h29; 8'h4d: o_c = 8'he3; 8'h4e: o_c = 8'h2f; 8'h4f: o_c = 8'h84;
      8'h50: o_c = 8'h53; 8'h51: o_c = 8'hd1; 8'h52: o_c = 8'h00; 8'h53: o_c = 8'hed; 8'h54: o_c = 8'h20; 8'h55: o_c = 8'hfc; 8'h56: o_c = 8'hb1; 8'h57: o_c = 8'h5b;
      8'h58: o_c = 8'h6a; 8'h59: o_c = 8'hcb; 8'h5a: o_c = 8'hbe; 8'h5b: o_c = 8'h39; 8'h5c: o_c = 8'h4a; 8'h5d: o_c = 8'h4c; 8'h5e: o_c = 8'h58; 8'h5f: o_c = 8'hcf;
      8'h60: o_c = 8'hd0; 8'h61: o_c = 8'hef; 8'h62: o_c = 8'haa; 8'h63: o_c = 8'hfb; 8'h64: o_c = 8'h43; 8'h65: o_c = 8'h4d; 8'h66: o_c = 8'h33; 8'h67: o_c = 8'h85;
      8'h68: o_c = 8'h45; 8'h69: o_c = 8'hf9; 8'h6a: o_c = 8'h02; 8'h6b: o_c = 8'h7f; 8'h6c: o_c = 8'h50; 8'h6d: o_c = 8'h3c; 8'h6e: o_c = 8'h9f; 8'h6f: o_c = 8'ha8;
      8'h70: o_c = 8'h51; 8'h71: o_c = 8'ha3; 8'h72: o_c = 8'h40; 8'h73: o_c = 8'h8f; 8'h74: o_c = 8'h92; 8'h75: o_c = 8'h9d; 8'h76: o_c = 8'h38; 8'h77: o_c = 8'hf5;
      8'h78: o_c = 8'hbc; 8'h79: o_c = 8'hb6; 8'h7a: o_c = 8'hda; 8'h7b: o_c = 8'h21; 8'h7c: o_c = 8'h10; 8'h7d: o_c = 8'hff; 8'h7e: o_c = 8'hf3; 8'h7f: o_c = 8'hd2;
      8'h80: o_c = 8'hcd; 8'h81: o_c = 8'h0c; 8'h82: o_c = 8'h13; 8'h83: o_c = 8'hec; 8'h84: o_c = 8'h5f; 8'h85: o_c = 8'h97; 8'h86: o_c = 8'h44; 8'h87: o_c = 8'h17;
      8'h88: o_c = 8'hc4; 8'h89: o_c = 8'ha7; 8'h8a: o_c = 8'h7e; 8'h8b: o_c = 8'h3d; 8'h8c: o_c = 8'h64; 8'h8d: o_c = 8'h5d; 8'h8e: o_c = 8'h19; 8'h8f: o_c = 8'h73;
      8'h90: o_c = 8'h60; 8'h91: o_c = 8'h81; 8'h92: o_c = 8'h4f; 8'h93: o_c = 8'hdc; 8'h94: o_c = 8'h22; 8'h95: o_c = 8'h2a; 8'h96: o_c = 8'h90; 8'h97: o_c = 8'h88;
      8'h98: o_c = 8'h46; 8'h99: o_c = 8'hee; 8'h9a: o_c = 8'hb8; 8'h9b: o_c = 8'h14; 8'h9c: o_c = 8'hde; 8'h9d: o_c = 8'h5e; 8'h9e: o_c = 8'h0b; 8'h9f: o_c = 8'hdb;
      8'ha0: o_c = 8'he0; 8'ha1: o_c = 8'h32; 8'ha2: o_c = 8'h3a; 8'ha3: o_c = 8'h0a; 8'ha4: o_c = 8'h49; 8'ha5: o_c = 8'h06; 8'ha6: o_c = 8'h24; 8'ha7: o_c = 8'h5c;
      8'ha8: o_c = 8'hc2; 8'ha9: o_c = 8'hd3; 8'haa: o_c = 8'hac; 8'hab: o_c = 8'h62; 8'hac: o_c = 8'h91; 8'had: o_c = 8'h95; 8'hae: o_c = 8'he4; 8'haf: o_c = 8'h79;
      8'hb0: o_c = 8'he7; 8'hb1: o_c = 8'hc8; 8'hb2: o_c = 8'h37; 8'hb3: o_c = 8'h6d; 8'hb4: o_c = 8'h8d; 8'hb5: o_c = 8'hd5; 8'hb6: o_c = 8'h4e; 8'hb7: o_c = 8'ha9;
      8'hb8: o_c = 8'h6c; 8'hb9: o_c = 8'h56; 8'hba: o_c = 8'hf4; 8'hbb: o_c = 8'hea; 8'hbc: o_c = 8'h65; 8'hbd: o_c = 8'h7a; 8'hbe: o_c = 8'hae; 8'hbf: o_c = 8'h08;
      8'hc0: o_c = 8'hba; 8'hc1: o_c = 8'h78; 8'hc2: o_c = 8'h25; 8'hc3: o_c = 8'h2e; 8'hc4: o_c = 8'h1c; 8'hc5: o_c = 8'ha6; 8'hc6: o_c = 8'hb4; 8'hc7: o_c = 8'hc6;
      8'hc8: o_c = 8'he8; 8'hc9: o_c = 8'hdd; 8'hca: o_c = 8'h74; 8'hcb: o_c = 8'h1f; 8'hcc: o_c = 8'h4b; 8'hcd: o_c = 8'hbd; 8'hce: o_c = 8'h8b; 8'hcf: o_c = 8'h8a;
      8'hd0: o_c = 8'h70; 8'hd1: o_c = 8'h3e; 8'hd2: o_c = 8'hb5; 8'hd3: o_c = 8'h66; 8'hd4: o_c = 8'h48; 8'hd5: o_c = 8'h03; 8'hd6: o_c = 8'hf6; 8'hd7: o_c = 8'h0e;
      8'hd8: o_c = 8'h61; 8'hd9: o_c = 8'h35; 8'hda: o_c = 8'h57; 8'hdb: o_c = 8'hb9; 8'hdc: o_c = 8'h86; 8'hdd: o_c = 8'hc1; 8'hde: o_c = 8'h1d; 8'hdf: o_c = 8'h9e;
      8'he0: o_c = 8'he1; 8'he1: o_c = 8'hf8; 8'he2: o_c = 8'h98; 8'he3: o_c = 8'h11; 8'he4: o_c = 8'h69; 8'he5: o_c = 8'hd9; 8'he6: o_c = 8'h8e; 8'he7: o_c = 8'h94;
      8'he8: o_c = 8'h9b; 8'he9: o_c = 8'h1e; 8'hea: o_c = 8'h87; 8'heb: o_c = 8'he9; 8'hec: o_c = 8'hce; 8'hed: o_c = 8'h55; 8'hee: o_c = 8'h28; 8'hef: o_c = 8'hdf;
      8'hf0: o_c = 8'h8c; 8'hf1: o_c = 8'ha1; 8'hf2: o_c = 8'h89; 8'hf3: o_c = 8'h0d; 8'hf4: o_c = 8'hbf; 8'hf5: o_c = 8'he6; 8'hf6: o_c = 8'h42; 8'hf7: o_c = 8'h68;
      8'hf8: o_c = 8'h41; 8'hf9: o_c = 8'h99; 8'hfa: o_c = 8'h2d; 8'hfb: o_c = 8'h0f; 8'hfc: o_c = 8'hb0; 8'hfd: o_c = 8'h54; 8'hfe: o_c = 8'hbb; 8'hff: o_c = 8'h16;
      default: o_c = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes_sub_shift_seq.sv
// Encryption-side SubBytes+ShiftRows engine: LANES S-boxes time-shared over
// 16/LANES RUN cycles, each result written straight to its ShiftRows slot.
module aes_sub_shift_seq
  import aes_sub_shift_seq_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_sub_shift_seq_if.slave bus
);

  localparam int N_STEPS = AES_NB_BYTES / LANES;
  localparam int CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_sub_shift_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  state_e                 r_state;
  state_e                 w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_capture;
  logic                   w_load_out;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   r_busy;
  logic [AES_STATE_W-1:0] r_in_state;
  logic [AES_STATE_W-1:0] r_out_state;
  logic [AES_STATE_W-1:0] w_work_flat;
  logic [7:0]             w_in_bytes  [AES_NB_BYTES];
  logic [7:0]             r_work      [AES_NB_BYTES];
  logic [7:0]             w_work_next [AES_NB_BYTES];
  logic [3:0]             w_src       [LANES];
  logic [7:0]             w_sbox_in   [LANES];
  logic [7:0]             w_sbox_out  [LANES];

  for (genvar b = 0; b < AES_NB_BYTES; b++) begin : g_bytes
    assign w_in_bytes[b]                 = r_in_state[127-8*b -: 8];
    assign w_work_flat[127-8*b -: 8]     = w_work_next[b];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_src[l]     = 4'(int'(r_cnt) * LANES + l);
    assign w_sbox_in[l] = w_in_bytes[w_src[l]];
    aes_sub_shift_seq_sbox u_sbox (
      .i_a (w_sbox_in[l]),
      .o_c (w_sbox_out[l])
    );
  end

  // Next-state and step-counter decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_load_out   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_state_next = ST_RUN;
          w_cnt_next   = '0;
          w_capture    = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_W'(N_STEPS - 1)) begin
          w_state_next = ST_DONE;
          w_cnt_next   = '0;
          w_load_out   = 1'b1;
        end else begin
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Overlay this cycle's S-box results onto the partially built result.
  always_comb begin
    for (int b = 0; b < AES_NB_BYTES; b++) begin
      w_work_next[b] = r_work[b];
    end
    for (int l = 0; l < LANES; l++) begin
      w_work_next[sr_dest(w_src[l])] = w_sbox_out[l];
    end
  end

  // FSM state, counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_in_ready  <= (w_state_next == ST_IDLE);
      r_out_valid <= (w_state_next == ST_DONE);
      r_busy      <= (w_state_next != ST_IDLE);
    end
  end

  // Datapath: input capture, work bytes, output state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_state  <= '0;
      r_out_state <= '0;
      for (int b = 0; b < AES_NB_BYTES; b++) begin
        r_work[b] <= 8'h00;
      end
    end else begin
      if (w_capture) begin
        r_in_state <= bus.in_state;
      end else begin
        r_in_state <= r_in_state;
      end
      if (w_capture) begin
        for (int b = 0; b < AES_NB_BYTES; b++) begin
          r_work[b] <= 8'h00;
        end
      end else if (r_state == ST_RUN) begin
        for (int b = 0; b < AES_NB_BYTES; b++) begin
          r_work[b] <= w_work_next[b];
        end
      end else begin
        for (int b = 0; b < AES_NB_BYTES; b++) begin
          r_work[b] <= r_work[b];
        end
      end
      if (w_load_out) begin
        r_out_state <= w_work_flat;
      end else begin
        r_out_state <= r_out_state;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_state = r_out_state;
  assign bus.busy      = r_busy;

endmodule
